imem_loader: RTL and testbench

Instruction-memory responder for the single-cycle CPU's fetch port. It returns `inst` combinationally for the CPU's `pc_out` so fetch completes in the same cycle. It also owns a byte-stream boot loader that fills the memory from a host link, holding the CPU in reset until a complete program image has been written. It sits between the top level's host/byte link and the CPU's `pc_out`/`inst` pins, and drives the CPU's `reset`.

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_loader_byte_assembler.sv | 28 ++
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_RUN  = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    localparam logic [31:0] NOP_INST          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs four MSB-first bytes into a 32-bit word; used for header and data alike.
module byte_assembler (
    input  logic        clock,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (accept) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {r_shift[15:0], data};
        end
    end

    // The word is presented on the same cycle as its 4th byte so the caller can act on that edge.
    assign word_valid = accept && (r_cnt == 2'd3);
    assign word       = {r_shift, data};

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a combinational fetch port and a byte-stream boot loader
// that holds the CPU in reset until a complete image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       pc,
    output logic [31:0]       inst,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    input  logic              reload,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_e            r_state;
    state_e            w_next;
    logic [31:0]       r_mem [DEPTH];
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W:0]   r_words;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_asm_clear;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic              w_last_word;
    logic [29:0]       w_word_off;
    logic              w_in_range;

    assign ld_ready    = !reset && ((r_state == S_HDR) || (r_state == S_DATA));
    assign w_accept    = ld_valid && ld_ready;
    // Count is held at zero outside loading, so it starts clean on every entry to HDR.
    assign w_asm_clear = reset || (r_state == S_RUN) || (r_state == S_ERR);

    byte_assembler u_asm (
        .clock      (clock),
        .clear      (w_asm_clear),
        .accept     (w_accept),
        .data       (ld_data),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    assign w_last_word = (r_words + {{ADDR_W{1'b0}}, 1'b1}) == r_n;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR: begin
                if (w_word_valid) begin
                    if (w_word == '0)
                        w_next = S_RUN;
                    else if (w_word > 32'(DEPTH))
                        w_next = S_ERR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA:  if (w_word_valid && w_last_word) w_next = S_RUN;
            S_RUN:   if (reload) w_next = S_HDR;
            S_ERR:   if (reload) w_next = S_HDR;
            default: w_next = S_HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_HDR;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_n         <= '0;
            r_words     <= '0;
        end else begin
            r_state     <= w_next;
            r_cpu_reset <= (w_next != S_RUN);
            r_done      <= (w_next == S_RUN);
            r_err       <= (w_next == S_ERR);
            if ((r_state == S_HDR) && w_word_valid)
                r_n <= w_word[ADDR_W:0];
            if ((w_next == S_HDR) && (r_state != S_HDR))
                r_words <= '0;
            else if ((r_state == S_DATA) && w_word_valid)
                r_words <= r_words + {{ADDR_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if ((r_state == S_DATA) && w_word_valid)
            r_mem[r_words[ADDR_W-1:0]] <= w_word;
    end

    // Word offset computed on pc[31:2]; BASE_ADDR is word aligned, so the low bits only gate alignment.
    assign w_word_off = pc[31:2] - BASE_ADDR[31:2];
    assign w_in_range = (pc >= BASE_ADDR) && (pc[1:0] == 2'b00) && (w_word_off[29:ADDR_W] == '0);
    assign inst       = w_in_range ? r_mem[w_word_off[ADDR_W-1:0]] : NOP_INST;

    assign cpu_reset    = r_cpu_reset;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word-array reference model.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] BASE   = 32'h0040_0000;

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_ready;
    logic              reload;
    logic              cpu_reset;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] model [DEPTH];
    bit          known [DEPTH];
    bit          tog = 1'b0;
    bit          track_release = 1'b0;
    int unsigned acc_cnt = 0;
    int unsigned exp_total = 0;

    always #5 clock = ~clock;

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clock        (clock),
        .reset        (reset),
        .pc           (pc),
        .inst         (inst),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .reload       (reload),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_inst(input logic [31:0] a);
        int unsigned idx;
        if (a < BASE || a[1:0] != 2'b00) return 32'h0;
        idx = (a - BASE) / 4;
        if (idx >= DEPTH) return 32'h0;
        return model[idx];
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bp);
        bit ok = 1'b0;
        bit acc;
        int unsigned waited = 0;
        while (!ok && waited < 64) begin
            @(negedge clock);
            ld_data  = b;
            ld_valid = bp ? tog : 1'b1;
            tog      = ~tog;
            acc      = ld_valid && ld_ready;
            @(posedge clock);
            waited++;
            if (acc) begin
                ok = 1'b1;
                #1;
                acc_cnt++;
                if (track_release)
                    check($sformatf("cpu_reset_edge%0d", acc_cnt), cpu_reset, acc_cnt < exp_total);
            end
        end
        if (!ok) check("byte_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit bp);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], bp);
    endtask

    task automatic idle_inputs();
        @(negedge clock);
        ld_valid = 1'b0;
    endtask

    // Loads n words from wq; the model takes the words once the image is complete.
    task automatic load_image(input int unsigned n, input logic [31:0] wq[$], input bit bp);
        acc_cnt   = 0;
        exp_total = 4 * n + 4;
        send_word(n, bp);
        for (int unsigned i = 0; i < n; i++) send_word(wq[i], bp);
        check("done_after_load", done, 1'b1);
        check("cpu_reset_after_load", cpu_reset, 1'b0);
        check("words_loaded", words_loaded, n);
        for (int unsigned i = 0; i < n; i++) begin
            model[i] = wq[i];
            known[i] = 1'b1;
        end
        idle_inputs();
    endtask

    task automatic do_reload();
        @(negedge clock);
        reload = 1'b1;
        @(posedge clock);
        #1;
        check("reload_cpu_reset", cpu_reset, 1'b1);
        check("reload_done", done, 1'b0);
        check("reload_err", err, 1'b0);
        check("reload_words", words_loaded, 0);
        @(negedge clock);
        reload = 1'b0;
        #1;
        check("reload_ready", ld_ready, 1'b1);
    endtask

    task automatic fetch_check(input string tag, input logic [31:0] a);
        pc = a;
        #1;
        check($sformatf("%s_%08h", tag, a), inst, exp_inst(a));
    endtask

    task automatic random_fetches(input int unsigned n);
        logic [31:0] a;
        for (int k = 0; k < 8; k++) begin
            a = BASE + 4 * $urandom_range(0, n - 1);
            fetch_check("fetch_rand", a);
        end
        for (int k = 0; k < 4; k++) begin
            a = $urandom;
            if (a >= BASE && a < BASE + 4 * DEPTH && a[1:0] == 2'b00 && !known[(a - BASE) / 4]) continue;
            fetch_check("fetch_any", a);
        end
    endtask

    initial begin
        logic [31:0] wq[$];
        int unsigned n;
        logic [31:0] w0;
        logic [31:0] w1;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            model[i] = 32'h0;
            known[i] = 1'b0;
        end
        reset = 1'b1; ld_valid = 1'b0; ld_data = 8'h00; reload = 1'b0; pc = BASE;

        repeat (3) @(posedge clock);
        #1;
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_words", words_loaded, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_ready", ld_ready, 1'b1);

        // Basic load with per-edge release tracking
        wq = '{32'h3C08_0001, 32'h2108_0002};
        track_release = 1'b1;
        load_image(2, wq, 1'b0);
        track_release = 1'b0;
        fetch_check("basic", BASE);
        fetch_check("basic", BASE + 4);
        check("basic_word1", inst, 32'h2108_0002);
        fetch_check("bound", 32'h003F_FFFC);
        fetch_check("bound", 32'h0040_1000);
        fetch_check("bound", 32'h0040_0002);
        check("bound_misaligned", inst, 32'h0);

        // Bytes offered in RUN are not consumed
        @(negedge clock);
        ld_valid = 1'b1; ld_data = 8'hAA;
        repeat (3) begin
            @(negedge clock);
            check("run_ready", ld_ready, 1'b0);
        end
        check("run_words_hold", words_loaded, 2);
        check("run_done_hold", done, 1'b1);
        ld_valid = 1'b0;

        // Random image under backpressure
        do_reload();
        n = $urandom_range(1, 8);
        wq = {};
        for (int unsigned i = 0; i < n; i++) wq.push_back($urandom);
        load_image(n, wq, 1'b1);
        random_fetches(n);

        // Empty image: memory untouched
        do_reload();
        load_image(0, wq, 1'b0);
        check("n0_done", done, 1'b1);
        random_fetches(n);

        // Oversize header
        do_reload();
        send_word(DEPTH + 1, 1'b0);
        idle_inputs();
        #1;
        check("over_err", err, 1'b1);
        check("over_ready", ld_ready, 1'b0);
        check("over_cpu_reset", cpu_reset, 1'b1);
        check("over_done", done, 1'b0);
        do_reload();

        // Full-depth image at the boundary
        wq = {};
        for (int unsigned i = 0; i < DEPTH; i++) wq.push_back($urandom);
        load_image(DEPTH, wq, 1'b0);
        fetch_check("full_last", BASE + 4 * (DEPTH - 1));
        fetch_check("full_past", BASE + 4 * DEPTH);
        random_fetches(DEPTH);

        // Reset mid-word after one completed word
        do_reload();
        w0 = $urandom;
        w1 = $urandom;
        send_word(3, 1'b0);
        send_word(w0, 1'b0);
        send_byte(w1[31:24], 1'b0);
        send_byte(w1[23:16], 1'b0);
        model[0] = w0;
        @(negedge clock);
        ld_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_ready", ld_ready, 1'b0);
        @(posedge clock);
        #1;
        check("midrst_cpu_reset", cpu_reset, 1'b1);
        check("midrst_words", words_loaded, 0);
        check("midrst_done", done, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        fetch_check("midrst_word0", BASE);
        fetch_check("midrst_word1_old", BASE + 4);
        wq = '{$urandom};
        load_image(1, wq, 1'b1);
        fetch_check("reload_word0", BASE);
        fetch_check("reload_word1_old", BASE + 4);
        random_fetches(DEPTH);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
